// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port instruction SRAM between fetch and the data-side path,
// with fetch priority, a starvation override for data, and tagged 1-cycle read-response routing.
module imem_arbiter #(
  parameter int               XLEN       = 32,
  parameter int               ADDR_W     = 13,
  parameter logic [XLEN-1:0]  BASE       = 32'h8000_0000,
  parameter int               STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              f_req_i,
  input  logic [XLEN-1:0]   f_addr_i,
  input  logic              f_kill_i,
  output logic              f_gnt_o,
  output logic              f_rvalid_o,
  output logic [XLEN-1:0]   f_rdata_o,
  output logic              f_err_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_be_i,
  input  logic [XLEN-1:0]   d_addr_i,
  input  logic [XLEN-1:0]   d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [XLEN-1:0]   d_rdata_o,
  output logic              d_err_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic [XLEN-1:0]   mem_rdata_i
);
  localparam int              SW   = $clog2(STARVE_MAX + 1);
  localparam logic [XLEN-1:0] SPAN = XLEN'(1) << (ADDR_W + 2);
  typedef enum logic [1:0] {NONE, FETCH, DATA, FETCH_KILLED} resp_t;
  resp_t           r_resp, w_resp, w_resp_nxt;
  logic [SW-1:0]   r_starve, w_starve_nxt;
  logic            r_err, r_wr_err;
  logic [XLEN-1:0] w_f_off, w_d_off;
  logic            w_f_in, w_d_in, w_in, w_force;
  assign w_f_off = f_addr_i - BASE;
  assign w_d_off = d_addr_i - BASE;
  assign w_f_in  = (f_addr_i >= BASE) && (w_f_off < SPAN);
  assign w_d_in  = (d_addr_i >= BASE) && (w_d_off < SPAN);
  // Data takes the port only once it has been denied STARVE_MAX cycles in a row
  assign w_force = d_req_i && (r_starve == SW'(STARVE_MAX));
  assign f_gnt_o = rstn_i && f_req_i && !w_force;
  assign d_gnt_o = rstn_i && d_req_i && !f_gnt_o;
  assign w_in    = d_gnt_o ? w_d_in : w_f_in;
  assign mem_en_o    = (f_gnt_o || d_gnt_o) && w_in;
  assign mem_we_o    = mem_en_o && d_gnt_o && d_we_i;
  assign mem_addr_o  = !mem_en_o ? '0 : d_gnt_o ? w_d_off[ADDR_W+1:2] : w_f_off[ADDR_W+1:2];
  assign mem_be_o    = mem_we_o ? d_be_i : {4{mem_en_o}};
  assign mem_wdata_o = mem_we_o ? d_wdata_i : '0;
  // A kill arriving in the response cycle suppresses the older fetch's data
  assign w_resp     = (r_resp == FETCH && f_kill_i) ? FETCH_KILLED : r_resp;
  assign f_rvalid_o = (w_resp == FETCH);
  assign f_err_o    = f_rvalid_o && r_err;
  assign f_rdata_o  = (f_rvalid_o && !r_err) ? mem_rdata_i : '0;
  assign d_rvalid_o = (w_resp == DATA);
  assign d_err_o    = (d_rvalid_o && r_err) || r_wr_err;
  assign d_rdata_o  = (d_rvalid_o && !r_err) ? mem_rdata_i : '0;
  always_comb begin
    w_resp_nxt   = f_gnt_o ? FETCH : (d_gnt_o && !d_we_i) ? DATA : NONE;
    w_starve_nxt = (!d_req_i || d_gnt_o) ? '0 :
                   (r_starve == SW'(STARVE_MAX)) ? r_starve : r_starve + SW'(1);
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_resp   <= NONE;
      r_starve <= '0;
      r_err    <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_resp   <= w_resp_nxt;
      r_starve <= w_starve_nxt;
      r_err    <= (f_gnt_o || d_gnt_o) && !w_in;
      r_wr_err <= d_gnt_o && d_we_i && !w_d_in;
    end
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: vector table plus hand sequences, with a cycle-aligned response scoreboard
// checked against a reference copy of SRAM contents.
module tb_imem_arbiter;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] FA   = 32'h8000_0020;
  localparam logic [31:0] DA   = 32'h8000_0100;
  logic        clk_i = 0, rstn_i = 0;
  logic        f_req_i = 0, f_kill_i = 0, d_req_i = 0, d_we_i = 0;
  logic [31:0] f_addr_i = 0, d_addr_i = 0, d_wdata_i = 0, mem_rdata_i = 0;
  logic [3:0]  d_be_i = 0;
  logic        f_gnt_o, f_rvalid_o, f_err_o, d_gnt_o, d_rvalid_o, d_err_o, mem_en_o, mem_we_o;
  logic [31:0] f_rdata_o, d_rdata_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [12:0] mem_addr_o;
  int checks = 0, errors = 0;

  typedef struct {
    logic fr; logic [31:0] fa; logic fk;
    logic dr; logic dw; logic [3:0] be; logic [31:0] da; logic [31:0] dd;
    logic efg; logic edg; logic een;
  } vec_t;
  typedef struct {
    logic fv; logic [31:0] fd; logic fe;
    logic dv; logic [31:0] dd; logic de;
  } rsp_t;
  rsp_t q[$];
  vec_t tbl[19];
  logic [31:0] sram[0:8191];
  logic [31:0] ref_mem[0:8191];

  always #5 clk_i = ~clk_i;

  imem_arbiter #(.XLEN(32), .ADDR_W(13), .BASE(BASE), .STARVE_MAX(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_kill_i(f_kill_i), .f_gnt_o(f_gnt_o),
    .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o), .f_err_o(f_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // SRAM environment: 1-cycle read latency, byte-masked writes
  always @(posedge clk_i)
    if (mem_en_o) begin
      if (mem_we_o) sram[mem_addr_o] <= bmerge(sram[mem_addr_o], mem_wdata_o, mem_be_o);
      else mem_rdata_i <= sram[mem_addr_o];
    end

  function automatic logic inr(input logic [31:0] a);
    return a >= BASE && a < BASE + 32'h8000;
  endfunction
  function automatic logic [12:0] widx(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o[14:2];
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic cyc(input vec_t v);
    rsp_t r, n;
    logic [31:0] a;
    f_req_i = v.fr; f_addr_i = v.fa; f_kill_i = v.fk;
    d_req_i = v.dr; d_we_i = v.dw; d_be_i = v.be; d_addr_i = v.da; d_wdata_i = v.dd;
    #1;
    r = '{default: 0};
    if (q.size() > 0) r = q.pop_front();
    if (v.fk) begin r.fv = 0; r.fd = 0; r.fe = 0; end
    chk("f_rvalid", 32'(f_rvalid_o), 32'(r.fv));
    chk("f_rdata", f_rdata_o, r.fd);
    chk("f_err", 32'(f_err_o), 32'(r.fe));
    chk("d_rvalid", 32'(d_rvalid_o), 32'(r.dv));
    chk("d_rdata", d_rdata_o, r.dd);
    chk("d_err", 32'(d_err_o), 32'(r.de));
    chk("f_gnt", 32'(f_gnt_o), 32'(v.efg));
    chk("d_gnt", 32'(d_gnt_o), 32'(v.edg));
    chk("mem_en", 32'(mem_en_o), 32'(v.een));
    chk("mem_we", 32'(mem_we_o), 32'(v.een && v.edg && v.dw));
    a = v.edg ? v.da : v.fa;
    if (v.een) begin
      chk("mem_addr", 32'(mem_addr_o), 32'(widx(a)));
      chk("mem_be", 32'(mem_be_o), 32'((v.edg && v.dw) ? v.be : 4'hF));
      chk("mem_wdata", mem_wdata_o, (v.edg && v.dw) ? v.dd : 32'h0);
    end
    n = '{default: 0};
    if (v.efg) begin
      n.fv = 1; n.fe = !inr(v.fa); n.fd = inr(v.fa) ? ref_mem[widx(v.fa)] : 32'h0;
    end else if (v.edg && !v.dw) begin
      n.dv = 1; n.de = !inr(v.da); n.dd = inr(v.da) ? ref_mem[widx(v.da)] : 32'h0;
    end else if (v.edg && v.dw) begin
      if (inr(v.da)) ref_mem[widx(v.da)] = bmerge(ref_mem[widx(v.da)], v.dd, v.be);
      else n.de = 1;
    end
    q.push_back(n);
    @(posedge clk_i); #1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      sram[i] = {i[15:0], ~i[15:0]};
      ref_mem[i] = {i[15:0], ~i[15:0]};
    end
    sram[4] = 32'h1111_2222;
    ref_mem[4] = 32'h1111_2222;
    tbl[0]  = '{1, BASE,     0, 0, 0, 0, 0, 0, 1, 0, 1};
    tbl[1]  = '{1, BASE + 4, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    for (int i = 2; i < 12; i++)
      tbl[i] = '{1, FA, 0, 1, 0, 0, DA, 0, !(i == 6 || i == 11), (i == 6 || i == 11), 1};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 1, 0, 0, 32'h7FFF_FFFC, 0, 0, 1, 0};
    tbl[14] = '{1, 32'h8000_8000, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[15] = '{0, 0, 0, 1, 1, 4'hF, 32'h9000_0000, 32'h1234, 0, 1, 0};
    tbl[16] = '{1, 32'h8000_7FFF, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    tbl[17] = '{0, 0, 0, 1, 0, 0, 32'h8000_0008, 0, 0, 1, 1};
    tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    f_req_i = 1; f_addr_i = BASE; d_req_i = 1; d_addr_i = DA;
    #12;
    chk("rst_gnt", {30'h0, f_gnt_o, d_gnt_o}, 32'h0);
    chk("rst_outs", {26'h0, f_rvalid_o, f_err_o, d_rvalid_o, d_err_o, mem_en_o, mem_we_o}, 32'h0);
    chk("rst_mem", {15'h0, mem_be_o, mem_addr_o}, 32'h0);
    f_req_i = 0; d_req_i = 0;
    @(posedge clk_i); #3 rstn_i = 1;
    q.push_back('{default: 0});
    @(posedge clk_i); #1;
    for (int i = 0; i < 19; i++) cyc(tbl[i]);
    // partial write then fetch of the same word
    cyc('{0, 0, 0, 1, 1, 4'b0011, 32'h8000_0010, 32'hDEAD_BEEF, 0, 1, 1});
    cyc('{1, 32'h8000_0010, 0, 0, 0, 0, 0, 0, 1, 0, 1});
    chk("rmw_word", f_rdata_o, 32'h1111_BEEF);
    cyc('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    // kill of an older fetch while a new one is granted
    cyc('{1, 32'h8000_0040, 0, 0, 0, 0, 0, 0, 1, 0, 1});
    cyc('{1, 32'h8000_0044, 1, 0, 0, 0, 0, 0, 1, 0, 1});
    cyc('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    // kill coinciding with a data response
    cyc('{0, 0, 0, 1, 0, 0, 32'h8000_000C, 0, 0, 1, 1});
    cyc('{1, 32'h8000_0048, 1, 0, 0, 0, 0, 0, 1, 0, 1});
    cyc('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    // asynchronous reset with a read outstanding
    cyc('{1, 32'h8000_0080, 0, 0, 0, 0, 0, 0, 1, 0, 1});
    f_req_i = 1; f_addr_i = BASE; d_req_i = 1; d_addr_i = DA;
    #1 rstn_i = 0;
    #1;
    chk("arst_gnt", {30'h0, f_gnt_o, d_gnt_o}, 32'h0);
    chk("arst_outs", {26'h0, f_rvalid_o, f_err_o, d_rvalid_o, d_err_o, mem_en_o, mem_we_o}, 32'h0);
    chk("arst_rdata", f_rdata_o | d_rdata_o, 32'h0);
    f_req_i = 0; d_req_i = 0;
    @(posedge clk_i); #3 rstn_i = 1;
    q.delete();
    q.push_back('{default: 0});
    @(posedge clk_i); #1;
    cyc('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    cyc('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbitrates the single-ported, word-wide synchronous instruction memory between the fetch stage and the data-side load/store path, which covers code loading and reads of constants from the text region. Fetch has priority by default. A starvation counter guarantees data-side progress. The block sits between the fetch stage, the LSU and the instruction SRAM. It tracks the owner of each outstanding read, routes the 1-cycle-latency response back to that owner, and discards fetch responses killed by a redirect.

## Interface
- XLEN, 32, data/address width
- ADDR_W, 13, SRAM word-address width (8192 words)
- BASE, 32'h8000_0000, byte address of SRAM word 0
- STARVE_MAX, 4, consecutive denied data-request cycles before data is forced a grant
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- f_req_i  in  1  fetch read request
- f_addr_i  in  XLEN  fetch byte address; bits [1:0] ignored
- f_kill_i  in  1  redirect/flush; discard the outstanding fetch response
- f_gnt_o  out  1  fetch request accepted this cycle
- f_rvalid_o  out  1  fetch read data valid
- f_rdata_o  out  XLEN  fetch read data
- f_err_o  out  1  fetch address out of range (with f_rvalid_o)
- d_req_i  in  1  data request
- d_we_i  in  1  1 = write, 0 = read
- d_be_i  in  4  write byte enables
- d_addr_i  in  XLEN  data byte address; bits [1:0] ignored
- d_wdata_i  in  XLEN  write data
- d_gnt_o  out  1  data request accepted this cycle
- d_rvalid_o  out  1  data read data valid (reads only)
- d_rdata_o  out  XLEN  data read data
- d_err_o  out  1  data address out of range (with d_rvalid_o, or as a 1-cycle pulse after a write grant)
- mem_en_o  out  1  SRAM access strobe
- mem_we_o  out  1  SRAM write
- mem_be_o  out  4  SRAM byte enables
- mem_addr_o  out  ADDR_W  SRAM word address = (addr − BASE)[ADDR_W+1:2]
- mem_wdata_o  out  XLEN  SRAM write data
- mem_rdata_i  in  XLEN  SRAM read data, valid the cycle after a read strobe

## Operation
- Grant is combinational in the request cycle; at most one grant per cycle.
- A requester holds req and its payload stable until it sees gnt.
- Priority: fetch wins unless starve_cnt == STARVE_MAX and d_req_i = 1, in which case data wins.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - +1 each cycle d_req_i = 1 and d_gnt_o = 0, saturating at STARVE_MAX;
  - cleared on d_gnt_o, or on any cycle with d_req_i = 0.
- Range check: in range iff BASE ≤ addr < BASE + 4·2^ADDR_W (unsigned).
  - Out-of-range grant: mem_en_o = 0; next cycle rvalid = 1, rdata = 0, err = 1 to the owner.
  - Out-of-range write: d_err_o pulses with d_rvalid_o = 0.
- In-range grant drives mem_en_o = 1, mem_addr_o and mem_we_o. On a data write it also drives mem_be_o and mem_wdata_o; otherwise mem_be_o = 4'hF and mem_wdata_o = 0.
- Response tag register: resp_q ∈ {NONE, FETCH, DATA, FETCH_KILLED}, updated every cycle from the current grant. Data writes leave it NONE.
- Response routing:
  - FETCH → f_rvalid_o = 1, f_rdata_o = mem_rdata_i.
  - DATA → d_rvalid_o = 1, d_rdata_o = mem_rdata_i.
  - FETCH_KILLED or NONE → no rvalid.
- Kill:
  - f_kill_i in cycle N turns a fetch granted in cycle N−1 into FETCH_KILLED, so no f_rvalid_o is produced in cycle N. If the tag was already loaded as FETCH in cycle N, f_rvalid_o is masked in that cycle.
  - A fetch granted in the same cycle N as the kill is kept; the kill applies only to older responses.
- rdata outputs are 0 whenever the corresponding rvalid is 0.
- A data write followed by a fetch of the same word returns the new data; this is SRAM behaviour and the block adds no forwarding.

## Timing
- Reset (asynchronous, rstn_i = 0): all outputs 0, resp_q = NONE, starve_cnt = 0.
- Reset asserted with a read outstanding drops the response; no rvalid is produced after release.
- Read latency: grant in cycle N → rvalid in cycle N+1. Back-to-back grants every cycle give full throughput.
- Write: grant in cycle N, SRAM written at the N/N+1 edge; no response except the d_err_o pulse for an out-of-range write.
- Continuous fetch with continuous d_req_i: data is granted on the cycle after STARVE_MAX denied cycles, i.e. the (STARVE_MAX+1)th request cycle. Fetch is denied only in that cycle.
- Simultaneous f_kill_i, fetch grant and a pending data response: the data response is unaffected.

## Test plan
- Reset, then f_req_i = 1 with f_addr_i = 0x8000_0000/0x8000_0004 on consecutive cycles → mem_addr_o = 0, then 1; f_rvalid_o on cycles 2 and 3 with SRAM words 0 and 1; d outputs stay 0.
- f_req_i and d_req_i held high continuously, STARVE_MAX = 4 → d_gnt_o first asserts on the 5th cycle with f_gnt_o = 0 in that cycle. starve_cnt then restarts, so the next d grant comes 5 cycles later.
- Data write d_be_i = 4'b0011, d_wdata_i = 0xDEAD_BEEF to 0x8000_0010, over old word 0x1111_2222 → subsequent fetch of 0x8000_0010 returns 0x1111_BEEF; no d_rvalid_o for the write.
- Fetch granted in cycle N and f_kill_i in N+1 with a new fetch granted in N+1 → no f_rvalid_o in N+1; f_rvalid_o in N+2 carries the new fetch's data.
- d read from 0x7FFF_FFFC and fetch from 0x8000_8000 (ADDR_W = 13) → mem_en_o = 0 for both; rvalid = 1, err = 1, rdata = 0 in the next cycle.
- rstn_i dropped asynchronously the cycle after a read grant → all outputs 0 immediately; no rvalid after reset release.
